// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle for mul_issue_ctrl: request in, multiplier start/done, tagged result out.
interface mul_issue_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_dst;

  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_product_low;
  logic [DATA_W-1:0] mul_product_high;
  logic              mul_done;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_low;
  logic [DATA_W-1:0] res_high;
  logic [TAG_W-1:0]  res_dst;
  logic              res_z;
  logic              res_n;
  logic              res_err;

  modport slave (
    input  req_valid, req_a, req_b, req_dst,
    input  mul_product_low, mul_product_high, mul_done,
    input  res_ready,
    output req_ready, mul_start, mul_a, mul_b,
    output res_valid, res_low, res_high, res_dst, res_z, res_n, res_err
  );

  modport master (
    output req_valid, req_a, req_b, req_dst,
    output mul_product_low, mul_product_high, mul_done,
    output res_ready,
    input  req_ready, mul_start, mul_a, mul_b,
    input  res_valid, res_low, res_high, res_dst, res_z, res_n, res_err
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Single-op sequencer in front of the 16-bit multiplier: issue, wait for done, hold tagged result.
// Optional WAIT timeout is compiled in with `define MUL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready high, operands latched on req_valid
// ISSUE  | one-cycle mul_start, done ignored
// WAIT   | wait for mul_done (or timeout), capture product and flags
// HOLD   | res_valid high until res_ready
module mul_issue_ctrl #(
  parameter int DATA_W         = 16,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic             clk,
  input logic             rst,
  mul_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [TAG_W-1:0]  r_dst;
  logic [DATA_W-1:0] r_low;
  logic [DATA_W-1:0] r_high;
  logic              r_z;
  logic              r_n;
  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_capture = (r_state == S_WAIT) && bus.mul_done;

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // done in the limit cycle excludes the timeout, so done wins the tie
  assign w_timeout = (r_state == S_WAIT) && !bus.mul_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == S_ISSUE)
      r_cnt <= '0;
    else if (r_state == S_WAIT)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= 1'b0;
    else if (w_timeout)
      r_err <= 1'b1;
  end

  assign bus.res_err = r_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_capture || w_timeout) w_next = S_HOLD;
      S_HOLD:  if (bus.res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.mul_start = 1'b0;
    bus.res_valid = 1'b0;
    case (r_state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_ISSUE: bus.mul_start = 1'b1;
      S_HOLD:  bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Flags come from the captured product, never from the multiplier's own status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_dst  <= '0;
      r_low  <= '0;
      r_high <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.req_a;
      r_b   <= bus.req_b;
      r_dst <= bus.req_dst;
    end else if (w_capture) begin
      r_low  <= bus.mul_product_low;
      r_high <= bus.mul_product_high;
      r_z    <= ({bus.mul_product_high, bus.mul_product_low} == '0);
      r_n    <= bus.mul_product_high[DATA_W-1];
    end else if (w_timeout) begin
      r_low  <= '0;
      r_high <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
    end
  end

  assign bus.mul_a    = r_a;
  assign bus.mul_b    = r_b;
  assign bus.res_low  = r_low;
  assign bus.res_high = r_high;
  assign bus.res_dst  = r_dst;
  assign bus.res_z    = r_z;
  assign bus.res_n    = r_n;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl; the bench itself plays the multiplier (start -> done after a set latency).
module tb_mul_issue_ctrl;

`ifdef MUL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 40;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_issue_ctrl_if #(.DATA_W(16), .TAG_W(4)) bus ();

  mul_issue_ctrl #(.DATA_W(16), .TAG_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dst;
    int          lat;
    logic [15:0] exp_low;
    logic [15:0] exp_high;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at the negedge; returns at the negedge after the accept edge.
  task automatic issue_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] dst);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_dst   = dst;
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    #1;
    chk("start_after_accept", bus.mul_start, 1);
    chk("mul_a", bus.mul_a, a);
    chk("mul_b", bus.mul_b, b);
    chk("req_ready_busy", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Raise done in the lat-th cycle after the start cycle; res_valid must appear right after it is sampled.
  task automatic feed_done(input int lat, input logic [15:0] lo, input logic [15:0] hi);
    bit early;
    early = 1'b0;
    repeat (lat) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b0 || bus.mul_start !== 1'b0) early = 1'b1;
    end
    chk("no_early_valid_or_restart", early, 0);
    @(negedge clk);
    bus.mul_done         = 1'b1;
    bus.mul_product_low  = lo;
    bus.mul_product_high = hi;
    @(posedge clk);
    #1;
    chk("res_valid_after_done", bus.res_valid, 1);
    @(negedge clk);
    bus.mul_done = 1'b0;
  endtask

  task automatic release_res();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_hs", bus.req_ready, 1);
    chk("res_valid_after_hs", bus.res_valid, 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bit ok_valid, ok_stable, ok_ready, ok_nostart;
    checks = 0;
    errors = 0;

    vecs[0] = '{16'h0003, 16'h0005, 4'hA, 4, 16'h000F, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 4'h3, 1, 16'h0001, 16'hFFFE, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h1234, 4'hF, 2, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0002, 4'h5, 3, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h0010, 4'h9, 6, 16'h2340, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h8001, 4'h6, 2, 16'h7FFF, 16'h8000, 1'b0, 1'b1};

    rst                  = 1'b1;
    bus.req_valid        = 1'b0;
    bus.req_a            = '0;
    bus.req_b            = '0;
    bus.req_dst          = '0;
    bus.mul_product_low  = '0;
    bus.mul_product_high = '0;
    bus.mul_done         = 1'b0;
    bus.res_ready        = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_low", bus.res_low, 0);
    chk("rst_res_high", bus.res_high, 0);
    chk("rst_res_flags", {bus.res_z, bus.res_n, bus.res_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue_req(vecs[i].a, vecs[i].b, vecs[i].dst);
      feed_done(vecs[i].lat, vecs[i].exp_low, vecs[i].exp_high);
      chk($sformatf("v%0d_low", i), bus.res_low, vecs[i].exp_low);
      chk($sformatf("v%0d_high", i), bus.res_high, vecs[i].exp_high);
      chk($sformatf("v%0d_z", i), bus.res_z, vecs[i].exp_z);
      chk($sformatf("v%0d_n", i), bus.res_n, vecs[i].exp_n);
      chk($sformatf("v%0d_dst", i), bus.res_dst, vecs[i].dst);
      chk($sformatf("v%0d_err", i), bus.res_err, 0);
      release_res();
    end

    // HOLD stall with a new request pending: nothing may move until the handshake
    issue_req(16'h1111, 16'h0002, 4'h7);
    feed_done(2, 16'h2222, 16'h0000);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h0101;
    bus.req_b     = 16'h0003;
    bus.req_dst   = 4'h2;
    ok_valid = 1'b1; ok_stable = 1'b1; ok_ready = 1'b1; ok_nostart = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b1) ok_valid = 1'b0;
      if (bus.res_low !== 16'h2222 || bus.res_dst !== 4'h7 || bus.mul_a !== 16'h1111) ok_stable = 1'b0;
      if (bus.req_ready !== 1'b0) ok_ready = 1'b0;
      if (bus.mul_start !== 1'b0) ok_nostart = 1'b0;
    end
    chk("stall_valid_held", ok_valid, 1);
    chk("stall_result_stable", ok_stable, 1);
    chk("stall_req_ready_low", ok_ready, 1);
    chk("stall_no_start", ok_nostart, 1);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_hs_req_ready", bus.req_ready, 1);
    chk("stall_hs_no_start", bus.mul_start, 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_next_start", bus.mul_start, 1);
    chk("stall_next_a", bus.mul_a, 16'h0101);
    @(negedge clk);
    bus.req_valid = 1'b0;
    feed_done(1, 16'h0303, 16'h0000);
    chk("stall_next_low", bus.res_low, 16'h0303);
    chk("stall_next_dst", bus.res_dst, 4'h2);
    release_res();

    // Stray done in IDLE and in ISSUE must be ignored
    @(negedge clk);
    bus.mul_done         = 1'b1;
    bus.mul_product_low  = 16'hDEAD;
    bus.mul_product_high = 16'hBEEF;
    ok_valid = 1'b1; ok_stable = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) ok_valid = 1'b0;
      if (bus.res_low !== 16'h0303 || bus.res_high !== 16'h0000) ok_stable = 1'b0;
    end
    chk("idle_done_no_state_change", ok_valid, 1);
    chk("idle_done_no_capture", ok_stable, 1);
    issue_req(16'h0002, 16'h0007, 4'h1);
    @(posedge clk);
    #1;
    chk("issue_done_no_hold", bus.res_valid, 0);
    chk("issue_done_no_capture", bus.res_low, 16'h0303);
    @(negedge clk);
    bus.mul_done = 1'b0;
    feed_done(1, 16'h000E, 16'h0000);
    chk("after_stray_low", bus.res_low, 16'h000E);
    chk("after_stray_dst", bus.res_dst, 4'h1);
    release_res();

    // Asynchronous reset in the middle of WAIT
    issue_req(16'h00FF, 16'h0101, 4'hC);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midwait_rst_req_ready", bus.req_ready, 1);
    chk("midwait_rst_start", bus.mul_start, 0);
    chk("midwait_rst_valid", bus.res_valid, 0);
    chk("midwait_rst_low", bus.res_low, 0);
    chk("midwait_rst_dst", bus.res_dst, 0);
    chk("midwait_rst_mul_ab", {bus.mul_a, bus.mul_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {bus.req_ready, bus.mul_start, bus.res_valid}, 3'b100);
    issue_req(16'h0010, 16'h0010, 4'h8);
    feed_done(2, 16'h0100, 16'h0000);
    chk("post_rst_low", bus.res_low, 16'h0100);
    release_res();

`ifdef MUL_TIMEOUT_EN
    // No done: timeout after 8 WAIT cycles, late done ignored, next accept clears err
    issue_req(16'h0005, 16'h0006, 4'h4);
    ok_valid = 1'b1;
    repeat (TO) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b0) ok_valid = 1'b0;
    end
    chk("to_no_early_valid", ok_valid, 1);
    @(posedge clk);
    #1;
    chk("to_valid", bus.res_valid, 1);
    chk("to_err", bus.res_err, 1);
    chk("to_product", {bus.res_high, bus.res_low}, 0);
    chk("to_flags", {bus.res_z, bus.res_n}, 0);
    @(negedge clk);
    bus.mul_done         = 1'b1;
    bus.mul_product_low  = 16'h001E;
    bus.mul_product_high = 16'h8000;
    @(posedge clk);
    #1;
    chk("to_late_done_ignored", {bus.res_high, bus.res_low, bus.res_n, bus.res_err}, {32'h0, 1'b0, 1'b1});
    @(negedge clk);
    bus.mul_done = 1'b0;
    release_res();
    issue_req(16'h0003, 16'h0003, 4'hB);
    chk("to_err_cleared", bus.res_err, 0);
    feed_done(1, 16'h0009, 16'h0000);
    chk("to_next_low", bus.res_low, 16'h0009);
    release_res();
    // done arriving in the limit cycle wins
    issue_req(16'h0004, 16'h0004, 4'hD);
    feed_done(TO, 16'h0010, 16'h0000);
    chk("tie_err", bus.res_err, 0);
    chk("tie_low", bus.res_low, 16'h0010);
    release_res();
`else
    // Without the timeout, WAIT persists well past any limit
    issue_req(16'h0005, 16'h0006, 4'h4);
    ok_valid = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0) ok_valid = 1'b0;
    end
    chk("no_timeout_wait_persists", ok_valid, 1);
    feed_done(1, 16'h001E, 16'h0000);
    chk("no_timeout_low", bus.res_low, 16'h001E);
    chk("no_timeout_err", bus.res_err, 0);
    release_res();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
